// File: rtl/risc_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM encoding, requester IDs and a counter-width helper.
package risc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection between fetch and load/store requesters,
// with a starvation guard that lets fetch through after a run of data grants.
module arb_pick
  import risc_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = cnt_width(STARVE_LIMIT)
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant
);

  logic fetch_due;

  // A limit of zero disables the guard entirely: data always wins.
  assign fetch_due = (STARVE_LIMIT != 0) && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant = REQ_D;
    if (if_req && !d_req) begin
      grant = REQ_IF;
    end else if (if_req && d_req && fetch_due) begin
      grant = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Each access runs IDLE -> ISSUE -> (WAIT) -> RESP; stall freezes the core meanwhile.
module mem_port_arbiter
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              stall
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam int LAT_W = cnt_width(MEM_LATENCY);

  // Handshake: a requester raises req with its address/data stable and holds
  // them until the one-cycle ack; req is only sampled in IDLE, so it may drop
  // in the cycle after ack without starting a second access.
  arb_state_e       state, state_nx;
  logic             win;
  logic             grant;
  logic             any_req;
  logic             lat_done;
  logic [CNT_W-1:0] starve_cnt;
  logic [LAT_W-1:0] lat_cnt;

  assign any_req  = if_req | d_req;
  assign lat_done = (lat_cnt == LAT_W'(MEM_LATENCY - 1));

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .starve_cnt(starve_cnt),
    .grant     (grant)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = mem_we ? RESP : WAIT;
      WAIT:    if (lat_done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win        <= REQ_IF;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (state == IDLE && any_req) begin
        win    <= grant;
        mem_en <= 1'b1;
        if (grant == REQ_D) begin
          mem_we   <= d_we;
          mem_addr <= d_addr;
          mem_din  <= d_wdata;
          // Count data wins only while fetch is actually waiting.
          if (if_req && starve_cnt != CNT_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
          mem_addr   <= if_addr;
          starve_cnt <= '0;
        end
      end
      if (state == ISSUE) lat_cnt <= '0;
      if (state == WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
        // Only reads pass through WAIT, so stores never touch d_rdata.
        if (lat_done) begin
          if (win == REQ_IF) if_rdata <= mem_dout;
          else               d_rdata  <= mem_dout;
        end
      end
    end
  end

  assign if_ack = (state == RESP) && (win == REQ_IF);
  assign d_ack  = (state == RESP) && (win == REQ_D);
  assign stall  = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
